// File: rtl/comm_responder.sv
// comm_responder: queues bytes from uart_rx and answers each one through uart_tx,
// either with a fixed character or with an echo of the queued byte.
//
// Ports:
//   CLK_50      single clock, rising edge
//   RST         synchronous active-high reset
//   rx_dv       one-cycle strobe, rx_byte valid
//   rx_byte     received byte
//   tx_active   uart_tx is shifting a frame
//   tx_done     one-cycle strobe from uart_tx at end of stop bit
//   tx_dv       one-cycle send strobe to uart_tx
//   tx_byte     byte to send, held until the next tx_dv
//   gp_out      last byte accepted into the queue
//   fifo_count  current queue occupancy
//   overflow    sticky, set when a byte is dropped
//
// Build option: define COMM_CRLF_EN to follow every response byte with CR, LF.
module comm_responder #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       ECHO       = 0,
    parameter logic [DATA_W-1:0] RESP_CHAR  = 8'h46
) (
    input  logic                         CLK_50,
    input  logic                         RST,
    input  logic                         rx_dv,
    input  logic [DATA_W-1:0]            rx_byte,
    input  logic                         tx_active,
    input  logic                         tx_done,
    output logic                         tx_dv,
    output logic [DATA_W-1:0]            tx_byte,
    output logic [DATA_W-1:0]            gp_out,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_READY = 4'd1,
        S_START      = 4'd2,
        S_WAIT_DONE  = 4'd3,
        S_DONE       = 4'd4
`ifdef COMM_CRLF_EN
        ,
        S_CR_READY   = 4'd5,
        S_CR_START   = 4'd6,
        S_CR_WAIT    = 4'd7,
        S_LF_READY   = 4'd8,
        S_LF_START   = 4'd9,
        S_LF_WAIT    = 4'd10
`endif
    } state_e;

    state_e              state_q, state_d;
    logic                tx_dv_q, tx_dv_d;
    logic [DATA_W-1:0]   tx_byte_q, tx_byte_d;
    logic [DATA_W-1:0]   gp_q, gp_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic                full_c;
    logic                empty_c;
    logic                pop_c;
    logic                push_ok_c;

    // Queue bookkeeping; a pop in the same cycle frees the slot for a push when full.
    always_comb begin
        full_c    = (count_q == CNT_W'(FIFO_DEPTH));
        empty_c   = (count_q == '0);
        pop_c     = (state_q == S_START);
        push_ok_c = rx_dv && (!full_c || pop_c);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        gp_d      = gp_q;
        ovf_d     = ovf_q;

        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            gp_d     = rx_byte;
        end
        if (rx_dv && !push_ok_c) begin
            ovf_d = 1'b1;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Response sequencer.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;

        case (state_q)
            S_IDLE: begin
                if (!empty_c) state_d = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (!tx_active) state_d = S_START;
            end
            S_START: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = (ECHO != 0) ? mem_q[rd_ptr_q] : RESP_CHAR;
                state_d   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_done) state_d = S_DONE;
            end
            S_DONE: begin
`ifdef COMM_CRLF_EN
                state_d = S_CR_READY;
`else
                state_d = S_IDLE;
`endif
            end
`ifdef COMM_CRLF_EN
            S_CR_READY: begin
                if (!tx_active) state_d = S_CR_START;
            end
            S_CR_START: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = DATA_W'(8'h0D);
                state_d   = S_CR_WAIT;
            end
            S_CR_WAIT: begin
                if (tx_done) state_d = S_LF_READY;
            end
            S_LF_READY: begin
                if (!tx_active) state_d = S_LF_START;
            end
            S_LF_START: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = DATA_W'(8'h0A);
                state_d   = S_LF_WAIT;
            end
            S_LF_WAIT: begin
                if (tx_done) state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK_50) begin
        if (RST) begin
            state_q   <= S_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            gp_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            gp_q      <= gp_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Queue storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge CLK_50) begin
        if (!RST && push_ok_c) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

    assign tx_dv      = tx_dv_q;
    assign tx_byte    = tx_byte_q;
    assign gp_out     = gp_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_comm_responder.sv
// Bench for comm_responder: a fixed-response and an echo instance share all inputs;
// a bench-side uart_tx stand-in answers each tx_dv with a busy period and tx_done.
module tb_comm_responder;

    localparam int unsigned DEPTH  = 4;
    localparam int          TX_LEN = 6;
`ifdef COMM_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    typedef logic [7:0] bq_t [$];

    logic       CLK_50   = 1'b0;
    logic       RST      = 1'b1;
    logic       rx_dv    = 1'b0;
    logic [7:0] rx_byte  = 8'h00;
    logic       stall    = 1'b0;
    logic       inj_done = 1'b0;
    logic       emu_done = 1'b0;
    int         emu_cnt  = 0;
    logic       tx_active, tx_done;

    logic       dv0, dv1, o0, o1;
    logic [7:0] b0, b1, gp0, gp1;
    logic [2:0] c0, c1;

    assign tx_active = (emu_cnt != 0) || stall;
    assign tx_done   = emu_done || inj_done;

    always #5 CLK_50 = ~CLK_50;

    comm_responder #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .ECHO(0), .RESP_CHAR(8'h46)) u_fix (
        .CLK_50(CLK_50), .RST(RST), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_active(tx_active), .tx_done(tx_done), .tx_dv(dv0), .tx_byte(b0),
        .gp_out(gp0), .fifo_count(c0), .overflow(o0));

    comm_responder #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .ECHO(1), .RESP_CHAR(8'h46)) u_echo (
        .CLK_50(CLK_50), .RST(RST), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_active(tx_active), .tx_done(tx_done), .tx_dv(dv1), .tx_byte(b1),
        .gp_out(gp1), .fifo_count(c1), .overflow(o1));

    // uart_tx stand-in: busy for TX_LEN cycles after each strobe, done and idle together.
    always @(negedge CLK_50) begin
        emu_done = 1'b0;
        if (dv1 === 1'b1) begin
            emu_cnt = TX_LEN;
        end else if (emu_cnt > 0) begin
            emu_cnt = emu_cnt - 1;
            if (emu_cnt == 0) emu_done = 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending bytes plus a send engine walking a list of
    // bytes per response (main byte, then CR and LF when enabled).
    localparam int M_IDLE = 0, M_ARM = 1, M_STROBE = 2, M_WAIT = 3, M_SETTLE = 4;
    logic [7:0]  mq [$];
    bit          m_ovf;
    bit          m_dv;
    logic [7:0]  m_gp, m_tx0, m_tx1;
    int          st = M_IDLE, k = 0, st_n, k_n;
    bit          pop, full;
    bit          chk_en = 1'b0;
    int unsigned edge_cnt = 0, last_done_edge = 0;
    bq_t         seen0, seen1;
    int          gaps [$];

    function automatic logic [7:0] send_byte(input bit echo, input int idx, input logic [7:0] head);
        if (idx == 1) return 8'h0D;
        if (idx == 2) return 8'h0A;
        return echo ? head : 8'h46;
    endfunction

    always @(posedge CLK_50) begin
        edge_cnt++;
        if (RST) begin
            mq.delete();
            m_ovf = 1'b0; m_dv = 1'b0; m_gp = 8'h00; m_tx0 = 8'h00; m_tx1 = 8'h00;
            st = M_IDLE; k = 0;
            chk_en = 1'b1;
        end else begin
            if (tx_done) last_done_edge = edge_cnt;
            pop  = (st == M_STROBE) && (k == 0);
            full = (mq.size() == DEPTH);
            m_dv = (st == M_STROBE);
            if (st == M_STROBE) begin
                m_tx0 = send_byte(1'b0, k, (mq.size() != 0) ? mq[0] : 8'h00);
                m_tx1 = send_byte(1'b1, k, (mq.size() != 0) ? mq[0] : 8'h00);
            end
            st_n = st; k_n = k;
            case (st)
                M_IDLE:   if (mq.size() != 0) begin st_n = M_ARM; k_n = 0; end
                M_ARM:    if (!tx_active) st_n = M_STROBE;
                M_STROBE: st_n = M_WAIT;
                M_WAIT: if (tx_done) begin
                    if (k == 0)      st_n = M_SETTLE;
                    else if (k == 1) begin st_n = M_ARM; k_n = 2; end
                    else             st_n = M_IDLE;
                end
                M_SETTLE: if (CRLF) begin st_n = M_ARM; k_n = 1; end else st_n = M_IDLE;
                default:  st_n = M_IDLE;
            endcase
            if (pop) void'(mq.pop_front());
            if (rx_dv) begin
                if (!full || pop) begin
                    mq.push_back(rx_byte);
                    m_gp = rx_byte;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            st = st_n; k = k_n;
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(posedge CLK_50) begin
        #1;
        if (chk_en) begin
            check("tx_dv fix", dv0, m_dv);
            check("tx_dv echo", dv1, m_dv);
            check("tx_byte fix", b0, m_tx0);
            check("tx_byte echo", b1, m_tx1);
            check("gp_out", gp1, m_gp);
            check("gp_out fix", gp0, m_gp);
            check("fifo_count", c1, mq.size());
            check("fifo_count fix", c0, mq.size());
            check("overflow", o1, m_ovf);
            check("overflow fix", o0, m_ovf);
            if (dv1 === 1'b1) begin
                seen0.push_back(b0);
                seen1.push_back(b1);
                gaps.push_back(int'(edge_cnt - last_done_edge));
            end
        end
    end

    task automatic push1(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(negedge CLK_50);
        rx_dv = 1'b0;
    endtask

    task automatic clear_seen();
        seen0.delete(); seen1.delete(); gaps.delete();
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK_50); #1;
            if (st == M_IDLE && mq.size() == 0 && emu_cnt == 0 && dv1 !== 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle timeout", 32'(ok), 32'd1);
        @(negedge CLK_50);
    endtask

    task automatic wait_dv();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK_50); #1;
            if (dv1 === 1'b1) begin ok = 1'b1; break; end
        end
        check("wait tx_dv timeout", 32'(ok), 32'd1);
    endtask

    task automatic check_seq(input string name, input bq_t got, input bq_t mains, input bit echo);
        bq_t exp;
        foreach (mains[i]) begin
            exp.push_back(echo ? mains[i] : 8'h46);
            if (CRLF) begin exp.push_back(8'h0D); exp.push_back(8'h0A); end
        end
        check({name, " length"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check(name, got[i], exp[i]);
        end
    endtask

    initial begin
        int unsigned n_edge;
        bq_t mains;

        // Reset for two edges with a receive strobe landing inside it.
        @(negedge CLK_50);
        rx_dv = 1'b1; rx_byte = 8'hAA;
        @(negedge CLK_50);
        rx_dv = 1'b0; RST = 1'b0;
        @(posedge CLK_50); #1;
        check("reset fifo_count", c1, 32'd0);
        check("reset tx_dv", dv1, 32'd0);
        check("reset tx_byte", b1, 32'd0);
        check("reset gp_out", gp1, 32'd0);
        check("reset overflow", o1, 32'd0);
        @(negedge CLK_50);
        repeat (6) @(negedge CLK_50);

        // Stray tx_done while idle must not start anything.
        inj_done = 1'b1;
        @(negedge CLK_50);
        inj_done = 1'b0;
        repeat (6) @(negedge CLK_50);

        // Single byte: strobe appears three edges after the receive edge.
        clear_seen();
        n_edge = edge_cnt + 1;
        push1(8'h41);
        wait_dv();
        check("first latency", edge_cnt - n_edge, 32'd3);
        check("fixed byte", b0, 32'h46);
        check("echo byte", b1, 32'h41);
        check("gp_out after 41", gp1, 32'h41);
        wait_idle();
        mains = '{8'h41};
        check_seq("seq fixed", seen0, mains, 1'b0);

        // Three bytes queued behind a busy transmitter, then drained in order.
        clear_seen();
        stall = 1'b1;
        push1(8'h31); push1(8'h32); push1(8'h33);
        inj_done = 1'b1;
        @(negedge CLK_50);
        inj_done = 1'b0;
        @(posedge CLK_50); #1;
        check("queued count", c1, 32'd3);
        @(negedge CLK_50);
        stall = 1'b0;
        wait_idle();
        mains = '{8'h31, 8'h32, 8'h33};
        check_seq("seq echo", seen1, mains, 1'b1);
        check_seq("seq fixed3", seen0, mains, 1'b0);
`ifndef COMM_CRLF_EN
        check("gap count", gaps.size(), 32'd3);
        if (gaps.size() == 3) begin
            check("gap 2", gaps[1], 32'd4);
            check("gap 3", gaps[2], 32'd4);
        end
`endif

        // Five pushes into a four-deep queue with the transmitter stalled.
        clear_seen();
        stall = 1'b1;
        push1(8'h51); push1(8'h52); push1(8'h53); push1(8'h54); push1(8'h55);
        @(posedge CLK_50); #1;
        check("full count", c1, 32'd4);
        check("overflow set", o1, 32'd1);
        check("gp_out 4th", gp1, 32'h54);
        @(negedge CLK_50);
        stall = 1'b0;
        wait_idle();
        mains = '{8'h51, 8'h52, 8'h53, 8'h54};
        check_seq("seq overflow", seen1, mains, 1'b1);

        // Reset while a response is in flight drops the queue and the sticky flag.
        clear_seen();
        push1(8'h71); push1(8'h72);
        wait_dv();
        @(negedge CLK_50);
        RST = 1'b1;
        @(negedge CLK_50);
        RST = 1'b0;
        @(posedge CLK_50); #1;
        check("midreset count", c1, 32'd0);
        check("midreset overflow", o1, 32'd0);
        check("midreset tx_dv", dv1, 32'd0);
        @(negedge CLK_50);
        wait_idle();
        check("midreset sends", seen1.size(), 32'd1);

        // Full queue with a push landing exactly on the pop cycle.
        clear_seen();
        stall = 1'b1;
        push1(8'h61); push1(8'h62); push1(8'h63); push1(8'h64);
        repeat (3) @(negedge CLK_50);
        stall = 1'b0;
        @(negedge CLK_50);
        push1(8'h65);
        @(posedge CLK_50); #1;
        check("pop+push overflow", o1, 32'd0);
        check("pop+push count", c1, 32'd4);
        check("pop+push gp_out", gp1, 32'h65);
        @(negedge CLK_50);
        wait_idle();
        mains = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        check_seq("seq pop+push", seen1, mains, 1'b1);

`ifdef COMM_CRLF_EN
        // One byte yields byte, CR, LF and a single pop.
        clear_seen();
        push1(8'h7A);
        wait_idle();
        check("crlf sends", seen1.size(), 32'd3);
        if (seen1.size() == 3) begin
            check("crlf byte0", seen1[0], 32'h7A);
            check("crlf byte1", seen1[1], 32'h0D);
            check("crlf byte2", seen1[2], 32'h0A);
        end
        check("crlf count", c1, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
